// File: rtl/ram_req_ctrl.sv
// Request-side controller for the 64x8 single-port RAM: issues registered
// read/write requests, absorbs the two-cycle read latency, returns read data.
module ram_req_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_out,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  logic rd_s1;
  logic rd_s2;
  logic accept;
  logic rsp_take;

  // At most one read in flight; a stalled response also blocks new requests.
  always_comb begin
    req_ready = !rst && !rd_s1 && !rd_s2 && !(rsp_valid && !rsp_ready);
    accept    = req_valid && req_ready;
    rsp_take  = rsp_valid && rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      rd_s1     <= 1'b0;
      rd_s2     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      ram_write <= accept && req_write;
      if (accept) begin
        ram_addr <= req_addr;
        if (req_write) begin
          ram_data <= req_wdata;
        end
      end

      rd_s1 <= accept && !req_write;
      rd_s2 <= rd_s1;

      if (accept && req_write) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end

      // A capture cannot coincide with a pending response: req_ready kept
      // the read out until the previous response was taken.
      if (rd_s2) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= ram_out;
      end else if (rsp_take) begin
        rsp_valid <= 1'b0;
      end

      if (rsp_take) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

endmodule
